// File: rtl/mux_rr_reg.sv
// mux_rr_reg: NCH-channel round-robin registered mux with packet lock and valid/ready output.
// Define MUX_RR_FORCE_SEL_EN to add the force_en/force_ch channel override ports.
module mux_rr_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_last,
    output logic [NCH-1:0]       in_ready,
`ifdef MUX_RR_FORCE_SEL_EN
    input  logic                 force_en,
    input  logic [SELW-1:0]      force_ch,
`endif
    output logic [WIDTH-1:0]     out_data,
    output logic [WIDTH-1:0]     out_data_neg,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);
    typedef enum logic {IDLE, LOCKED} state_t;

    // Returns {found, index} of the first valid channel after p, wrapping modulo NCH.
    function automatic logic [SELW:0] rr_pick(input logic [NCH-1:0] v, input logic [SELW-1:0] p);
        logic [SELW-1:0] idx;
        rr_pick = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = SELW'((int'(p) + k) % NCH);
            if (v[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    state_t           state_q, state_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d, neg_q, neg_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic             last_q, last_d, valid_q, valid_d;
    logic [WIDTH-1:0] ch_data [NCH];
    logic [SELW:0]    idle_pick;
    logic             sel_vld, acc;
    logic [SELW-1:0]  sel_ch;

    for (genvar g = 0; g < NCH; g++) begin : g_split
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

`ifdef MUX_RR_FORCE_SEL_EN
    localparam int PW = 1 << SELW;
    logic [PW-1:0] vpad;
    // Padding keeps out-of-range force_ch values reading an always-invalid channel.
    assign vpad      = PW'(in_valid);
    assign idle_pick = force_en ? {vpad[force_ch], force_ch} : rr_pick(in_valid, ptr_q);
`else
    assign idle_pick = rr_pick(in_valid, ptr_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= SELW'(NCH - 1);
            data_q  <= '0;
            neg_q   <= '1;
            ch_q    <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            neg_q   <= neg_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    // While locked, ptr_q is the owning channel since every accept updates it.
    always_comb begin
        {sel_vld, sel_ch} = (state_q == LOCKED) ? {in_valid[ptr_q], ptr_q} : idle_pick;
        acc     = !rst && (!valid_q || out_ready) && sel_vld;
        state_d = acc ? (in_last[sel_ch] ? IDLE : LOCKED) : state_q;
        ptr_d   = acc ? sel_ch : ptr_q;
        data_d  = acc ? ch_data[sel_ch] : data_q;
        neg_d   = acc ? ~ch_data[sel_ch] : neg_q;
        ch_d    = acc ? sel_ch : ch_q;
        last_d  = acc ? in_last[sel_ch] : last_q;
        valid_d = acc || (valid_q && !out_ready);
    end

    always_comb begin
        in_ready     = acc ? (NCH'(1) << sel_ch) : '0;
        out_data     = data_q;
        out_data_neg = neg_q;
        out_ch       = ch_q;
        out_last     = last_q;
        out_valid    = valid_q;
    end
endmodule

// File: tb/tb_mux_rr_reg.sv
// tb_mux_rr_reg: directed checks of round-robin, packet lock, backpressure and reset for mux_rr_reg.
module tb_mux_rr_reg;
    logic        clk = 1'b0;
    logic        rst, out_ready, out_last, out_valid, force_en;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_last, in_ready;
    logic [7:0]  out_data, out_data_neg, d, nd;
    logic [1:0]  out_ch, force_ch;
    int          total = 0, bad = 0;

    mux_rr_reg #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
`ifdef MUX_RR_FORCE_SEL_EN
        .force_en(force_en), .force_ch(force_ch),
`endif
        .out_data(out_data), .out_data_neg(out_data_neg), .out_ch(out_ch), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cr(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, 32'(in_ready), 32'(exp));
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setd(input int i, input logic [7:0] v);
        in_data[i*8 +: 8] = v;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b0;
        force_en = 1'b0; force_ch = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_neg", 32'(out_data_neg), 32'hFF);
        chk("rst_ch", 32'(out_ch), 0);
        chk("rst_last", 32'(out_last), 0);
        in_valid = 4'hF; out_ready = 1'b1;
        cr("rst_in_ready", 4'b0000);
        in_valid = '0;
        rst = 1'b0;
        tick;
        chk("idle_valid", 32'(out_valid), 0);
        cr("idle_in_ready", 4'b0000);

        for (int i = 0; i < 4; i++) setd(i, 8'hA0 + 8'(i));
        in_valid = 4'hF; in_last = 4'hF;
        for (int n = 0; n < 6; n++) begin
            d  = 8'hA0 + 8'(n % 4);
            nd = ~d;
            cr("rr_ready", 4'(1 << (n % 4)));
            tick;
            chk("rr_ch", 32'(out_ch), 32'(n % 4));
            chk("rr_data", 32'(out_data), 32'(d));
            chk("rr_neg", 32'(out_data_neg), 32'(nd));
            chk("rr_valid", 32'(out_valid), 1);
        end
        in_valid = '0;
        cr("drain_ready", 4'b0000);
        tick;
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_hold_data", 32'(out_data), 32'hA1);
        chk("drain_hold_ch", 32'(out_ch), 1);

        setd(2, 8'h21); in_valid = 4'b0111; in_last = 4'b0011;
        cr("lock_b1_ready", 4'b0100);
        tick;
        chk("lock_b1_ch", 32'(out_ch), 2);
        chk("lock_b1_data", 32'(out_data), 32'h21);
        chk("lock_b1_last", 32'(out_last), 0);
        in_valid = 4'b0011;
        cr("lock_gap_ready", 4'b0000);
        tick;
        chk("lock_gap_valid", 32'(out_valid), 0);
        in_valid = 4'b0111; setd(2, 8'h22);
        cr("lock_b2_ready", 4'b0100);
        tick;
        chk("lock_b2_ch", 32'(out_ch), 2);
        chk("lock_b2_data", 32'(out_data), 32'h22);
        setd(2, 8'h23); in_last = 4'b0111;
        cr("lock_b3_ready", 4'b0100);
        tick;
        chk("lock_b3_ch", 32'(out_ch), 2);
        chk("lock_b3_data", 32'(out_data), 32'h23);
        chk("lock_b3_last", 32'(out_last), 1);
        cr("unlock_ready", 4'b0001);
        tick;
        chk("unlock_ch", 32'(out_ch), 0);
        chk("unlock_data", 32'(out_data), 32'hA0);
        in_valid = '0;
        tick;
        chk("lock_drain_valid", 32'(out_valid), 0);

        setd(1, 8'h3C); in_valid = 4'b0010; in_last = 4'hF;
        cr("bp_load_ready", 4'b0010);
        tick;
        chk("bp_load_data", 32'(out_data), 32'h3C);
        out_ready = 1'b0; in_valid = 4'b0101; setd(2, 8'h55);
        for (int n = 0; n < 4; n++) begin
            cr("bp_ready", 4'b0000);
            tick;
            chk("bp_data", 32'(out_data), 32'h3C);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_ch", 32'(out_ch), 1);
        end
        out_ready = 1'b1;
        cr("bp_release_ready", 4'b0100);
        tick;
        chk("bp_release_ch", 32'(out_ch), 2);
        chk("bp_release_data", 32'(out_data), 32'h55);
        chk("bp_release_valid", 32'(out_valid), 1);

        setd(3, 8'h77); in_valid = 4'b1000; in_last = 4'b0111;
        cr("mr_b1_ready", 4'b1000);
        tick;
        chk("mr_b1_ch", 32'(out_ch), 3);
        chk("mr_b1_last", 32'(out_last), 0);
        rst = 1'b1;
        cr("mr_rst_ready", 4'b0000);
        tick;
        chk("mr_rst_valid", 32'(out_valid), 0);
        rst = 1'b0; in_valid = 4'b1010; setd(1, 8'h11); in_last = 4'hF;
        cr("mr_after_ready", 4'b0010);
        tick;
        chk("mr_after_ch", 32'(out_ch), 1);
        chk("mr_after_data", 32'(out_data), 32'h11);

`ifdef MUX_RR_FORCE_SEL_EN
        in_valid = 4'hF; in_last = 4'hF; force_en = 1'b1; force_ch = 2'd3;
        for (int n = 0; n < 3; n++) begin
            cr("force_ready", 4'b1000);
            tick;
            chk("force_ch_out", 32'(out_ch), 3);
        end
        force_ch = 2'd0; in_last = 4'b1110;
        cr("force_lock_ready", 4'b0001);
        tick;
        chk("force_lock_ch", 32'(out_ch), 0);
        force_ch = 2'd3;
        cr("force_ign_ready", 4'b0001);
        tick;
        chk("force_ign_ch", 32'(out_ch), 0);
        in_last = 4'hF;
        cr("force_end_ready", 4'b0001);
        tick;
        chk("force_end_last", 32'(out_last), 1);
        cr("force_after_ready", 4'b1000);
        tick;
        chk("force_after_ch", 32'(out_ch), 3);
        force_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer. Successor to the single-bit 2:1 mux.
- Selection is made by a round-robin arbiter instead of an external select.
- Multi-beat packets are locked to one channel until the last beat.
- Output is a single registered stage with a valid/ready handshake, delivering true and inverted data. Sits between several producers and one shared downstream consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, number of input channels (2..16).
- SELW, 2, channel-index width; must equal clog2(NCH), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel beat valid.
- in_last  input  NCH  per-channel last-beat-of-packet flag.
- in_ready  output  NCH  per-channel beat accepted when in_valid[i] & in_ready[i].
- out_data  output  WIDTH  registered selected data.
- out_data_neg  output  WIDTH  bitwise inverse of out_data, same register stage.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_last  output  1  registered in_last of the held beat.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts when out_valid & out_ready.

Behaviour:
- Reset: rst is sampled at posedge clk. It is synchronous and active-high.
  - Outputs on reset: out_valid=0, out_data=0, out_data_neg=all ones, out_ch=0, out_last=0, in_ready=0 during the reset cycle.
  - Internal state on reset: state=IDLE, ptr=NCH-1.
- Load condition: load = !out_valid | out_ready. The output register can take a new beat in the same cycle the held one drains.
- in_ready[i] = load & grant_onehot[i]. It is combinational from out_ready, in_valid and state, with at most one bit set.
- Arbitration in IDLE:
  - Grant the first channel with in_valid set, searching ptr+1, ptr+2, … modulo NCH.
  - If no channel is valid, there is no grant.
- Arbitration in LOCKED(c): the grant is channel c only. Other channels are never granted, even if c is idle.
- On an accepted beat from channel g:
  - Capture out_data=data[g], out_data_neg=~data[g], out_ch=g, out_last=in_last[g], out_valid=1.
  - ptr=g.
- State transitions:
  - IDLE -> LOCKED(g) when the accepted beat has in_last=0.
  - LOCKED(g) -> IDLE when an accepted beat has in_last=1.
  - All other cycles keep the current state.
- Single-beat packet: in_last=1 on a beat in IDLE stays in IDLE, and ptr advances.
- Drain without refill: out_valid & out_ready with no grant clears out_valid. Data, neg, ch and last hold their values.
- Backpressure: out_valid & !out_ready leaves every register unchanged and all in_ready=0.
- Latency: accepted beat to out_valid is 1 cycle. Full throughput is 1 beat/cycle when out_ready=1.
- Fairness: each of K continuously requesting channels (single-beat packets) receives exactly 1 grant every K accepted beats.
- Reset mid-packet: the lock is dropped, ptr returns to NCH-1, and the held beat is discarded.
- X handling: in simulation, an X on in_valid/in_last of the granted channel propagates to the outputs. Synthesis treats it as don't-care. No X filtering is added.

Optional Feature:
- Macro: MUX_RR_FORCE_SEL_EN.
- Defined: adds ports force_en (input, 1) and force_ch (input, SELW).
  - While force_en=1 in IDLE, the grant is force_ch only (if valid). Round-robin search is bypassed and ptr still updates to the granted channel.
  - In LOCKED(c), force_en is ignored until the packet ends.
  - force_ch >= NCH yields no grant.
- Undefined: these ports do not exist, and behaviour is pure round-robin as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all in_valid=0.
  - Expect out_valid=0, out_data=8'h00, out_data_neg=8'hFF, in_ready=4'b0000.
- Round-robin: NCH=4, all 4 channels valid continuously with in_last=1, data ch i=8'hA0+i, out_ready=1.
  - Expect out_ch sequence 0,1,2,3,0,1.
  - Expect out_data A0,A1,A2,A3,A0; out_data_neg 5F,5E,5D,5C.
- Packet lock: ch2 sends 3 beats (last on the 3rd) while ch0 and ch1 stay valid.
  - Expect out_ch=2,2,2, then 0 (search from ptr=2 wraps: 3 is idle, 0 is first).
  - Expect in_ready[0] and in_ready[1] to be 0 for the first 3 accept cycles.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 from ch1 holding 8'h3C.
  - Expect out_data=8'h3C stable, in_ready=0, state unchanged.
  - Release out_ready: the next beat loads in the same cycle the held beat drains.
- Mid-packet reset: ch3 sends beat 1 with last=0, then rst=1 for 1 cycle, then ch1 and ch3 are valid.
  - Expect out_valid=0 after reset.
  - Expect the first grant to go to ch1 (from ptr=3, search order 0,1,…; ch0 is idle), confirming IDLE and no lock on ch3.
- Force (MUX_RR_FORCE_SEL_EN defined): force_en=1, force_ch=3, all channels valid.
  - Expect only ch3 granted each cycle.
  - Expect force_ch=3 to be ignored while locked to ch0 mid-packet, until ch0's last beat.
